// File: rtl/prbs31_pkg.sv
// Shared types and constants for the PRBS31 sequencer and its LFSR instances.
package prbs31_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SYNC   = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        CMD_NOP       = 2'd0,
        CMD_LOAD_SEED = 2'd1,
        CMD_START     = 2'd2,
        CMD_STOP      = 2'd3
    } cmd_t;

    // x^31 + x^28 + 1 expressed as state bit positions
    localparam int PRBS_TAP_HI = 30;
    localparam int PRBS_TAP_LO = 27;

    localparam logic [30:0] FALLBACK_SEED = 31'h7FFF_FFFF;

    // An all-zero LFSR state never leaves zero, so substitute the fallback
    function automatic logic [30:0] effective_seed(input logic [30:0] seed);
        return (seed == '0) ? FALLBACK_SEED : seed;
    endfunction

endpackage

// File: rtl/prbs31_lfsr.sv
// 31-bit PRBS31 shift register; shared by the pattern generator and the checker.
module prbs31_lfsr
    import prbs31_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [30:0] load_val,
    input  logic        step,
    input  logic        inject_sel,
    input  logic        inject_bit,
    output logic [30:0] state,
    output logic        next_bit
);

    assign next_bit = state[PRBS_TAP_HI] ^ state[PRBS_TAP_LO];

    // inject_sel lets the checker shift in the received bit instead of its own prediction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= '0;
        end else if (load) begin
            state <= load_val;
        end else if (step) begin
            state <= {state[29:0], (inject_sel ? inject_bit : next_bit)};
        end
    end

endmodule

// File: rtl/prbs31_seq_ctrl.sv
// Command-driven PRBS31 sequencer: seed loading, pattern generation and a
// self-synchronising checker with lock/loss tracking and a saturating error count.
module prbs31_seq_ctrl
    import prbs31_pkg::*;
#(
    parameter int LOCK_BITS = 32,
    parameter int LOSS_BITS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       cmd_valid,
    input  logic [1:0] cmd,
    input  logic [7:0] seed_byte,
    input  logic       rx_bit,
    output logic       tx_bit,
    output logic       busy,
    output logic       locked,
    output logic [7:0] err_count
);

    state_t      state_q, state_d;
    cmd_t        cmd_code;
    logic [31:0] seed_q;
    logic [30:0] start_seed;
    logic [4:0]  fill_cnt;
    logic [7:0]  match_cnt;
    logic [3:0]  miss_cnt;
    logic        gen_load, gen_step, gen_bit;
    logic        chk_step, chk_inject_rx, chk_bit;
    logic        do_start, do_stop, do_load_seed;
    logic        fill_full, rx_match, lock_hit, loss_hit;
    logic [30:0] unused_gen_state, unused_chk_state;
    logic        unused_seed_msb;

    assign cmd_code        = cmd_t'(cmd);
    assign start_seed      = effective_seed(seed_q[30:0]);
    assign unused_seed_msb = seed_q[31];
    assign fill_full       = (fill_cnt == 5'd31);
    assign rx_match        = (rx_bit == chk_bit);
    assign lock_hit        = (state_q == ST_SYNC) && fill_full && rx_match
                             && (match_cnt == 8'(LOCK_BITS - 1));
    assign loss_hit        = (state_q == ST_LOCKED) && !rx_match
                             && (miss_cnt == 4'(LOSS_BITS - 1));
    assign busy            = (state_q != ST_IDLE);
    assign locked          = (state_q == ST_LOCKED);

    prbs31_lfsr u_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (gen_load),
        .load_val   (start_seed),
        .step       (gen_step),
        .inject_sel (1'b0),
        .inject_bit (1'b0),
        .state      (unused_gen_state),
        .next_bit   (gen_bit)
    );

    prbs31_lfsr u_chk (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (1'b0),
        .load_val   (31'd0),
        .step       (chk_step),
        .inject_sel (chk_inject_rx),
        .inject_bit (rx_bit),
        .state      (unused_chk_state),
        .next_bit   (chk_bit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // START/STOP take priority over any lock or loss decision in the same cycle
    always_comb begin
        state_d       = state_q;
        do_start      = 1'b0;
        do_stop       = 1'b0;
        do_load_seed  = 1'b0;
        gen_load      = 1'b0;
        gen_step      = 1'b0;
        chk_step      = 1'b0;
        chk_inject_rx = 1'b0;
        if (ena) begin
            do_load_seed = cmd_valid && (cmd_code == CMD_LOAD_SEED);
            if (cmd_valid && (cmd_code == CMD_START)) begin
                do_start = 1'b1;
                gen_load = 1'b1;
                state_d  = ST_SYNC;
            end else if (cmd_valid && (cmd_code == CMD_STOP)) begin
                do_stop = 1'b1;
                state_d = ST_IDLE;
            end else if (state_q != ST_IDLE) begin
                gen_step      = 1'b1;
                chk_step      = 1'b1;
                chk_inject_rx = (state_q == ST_SYNC);
                if (lock_hit) begin
                    state_d = ST_LOCKED;
                end else if (loss_hit) begin
                    state_d = ST_SYNC;
                end
            end
        end
    end

    // In SYNC mismatches only restart the match run; the fill count is kept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seed_q    <= '0;
            fill_cnt  <= '0;
            match_cnt <= '0;
            miss_cnt  <= '0;
            err_count <= '0;
            tx_bit    <= 1'b0;
        end else begin
            if (do_load_seed) begin
                seed_q <= {seed_q[23:0], seed_byte};
            end
            if (do_start) begin
                err_count <= '0;
                fill_cnt  <= '0;
                match_cnt <= '0;
                miss_cnt  <= '0;
                tx_bit    <= 1'b0;
            end else if (do_stop) begin
                tx_bit <= 1'b0;
            end else if (gen_step) begin
                tx_bit <= gen_bit;
                if (state_q == ST_SYNC) begin
                    if (!fill_full) begin
                        fill_cnt <= fill_cnt + 5'd1;
                    end else if (rx_match) begin
                        match_cnt <= match_cnt + 8'd1;
                    end else begin
                        match_cnt <= '0;
                    end
                end else begin
                    if (!rx_match && (err_count != 8'hFF)) begin
                        err_count <= err_count + 8'd1;
                    end
                    if (loss_hit) begin
                        fill_cnt  <= '0;
                        match_cnt <= '0;
                        miss_cnt  <= '0;
                    end else if (!rx_match) begin
                        miss_cnt <= miss_cnt + 4'd1;
                    end else begin
                        miss_cnt <= '0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_prbs31_seq_ctrl.sv
// Self-checking bench for prbs31_seq_ctrl: directed vector table, multi-cycle
// corner sequences and randomized traffic against a bit-history reference model.
module tb_prbs31_seq_ctrl;

    localparam int LOCK_BITS = 32;
    localparam int LOSS_BITS = 4;

    localparam bit [1:0] C_NOP   = 2'd0;
    localparam bit [1:0] C_LOAD  = 2'd1;
    localparam bit [1:0] C_START = 2'd2;
    localparam bit [1:0] C_STOP  = 2'd3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic       cmd_valid;
    logic [1:0] cmd;
    logic [7:0] seed_byte;
    logic       rx_bit;
    logic       tx_bit;
    logic       busy;
    logic       locked;
    logic [7:0] err_count;

    int checks   = 0;
    int failures = 0;

    prbs31_seq_ctrl #(.LOCK_BITS(LOCK_BITS), .LOSS_BITS(LOSS_BITS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .cmd_valid (cmd_valid),
        .cmd       (cmd),
        .seed_byte (seed_byte),
        .rx_bit    (rx_bit),
        .tx_bit    (tx_bit),
        .busy      (busy),
        .locked    (locked),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    // Reference model: mode 0 idle, 1 sync, 2 locked; LFSRs kept as bit histories
    int        m_mode;
    bit [31:0] m_seed;
    bit        m_gen[$];
    bit        m_chk[$];
    int        m_run;
    int        m_miss;
    int        m_err;
    bit        m_tx;

    function automatic void modelReset();
        m_mode = 0;
        m_seed = '0;
        m_gen.delete();
        m_chk.delete();
        m_run  = 0;
        m_miss = 0;
        m_err  = 0;
        m_tx   = 1'b0;
    endfunction

    // Bit the generator will emit on the next enabled step (bit 31 back xor bit 28 back)
    function automatic bit modelNextGen();
        if (m_gen.size() != 31) return 1'b0;
        return m_gen[0] ^ m_gen[3];
    endfunction

    function automatic void modelStep(bit cv, bit [1:0] c, bit [7:0] b, bit rx);
        bit [30:0] s;
        bit        g;
        bit        p;
        if (cv && c == C_LOAD) m_seed = {m_seed[23:0], b};
        if (cv && c == C_START) begin
            s = m_seed[30:0];
            if (s == 31'd0) s = 31'h7FFF_FFFF;
            m_gen.delete();
            for (int i = 30; i >= 0; i--) m_gen.push_back(s[i]);
            m_chk.delete();
            m_err  = 0;
            m_run  = 0;
            m_miss = 0;
            m_mode = 1;
            m_tx   = 1'b0;
        end else if (cv && c == C_STOP) begin
            m_mode = 0;
            m_tx   = 1'b0;
        end else if (m_mode != 0) begin
            g = m_gen[0] ^ m_gen[3];
            m_gen.push_back(g);
            void'(m_gen.pop_front());
            m_tx = g;
            if (m_mode == 1) begin
                if (m_chk.size() < 31) begin
                    m_chk.push_back(rx);
                end else begin
                    p = m_chk[0] ^ m_chk[3];
                    m_chk.push_back(rx);
                    void'(m_chk.pop_front());
                    if (rx == p) begin
                        m_run++;
                        if (m_run == LOCK_BITS) begin
                            m_mode = 2;
                            m_miss = 0;
                        end
                    end else begin
                        m_run = 0;
                    end
                end
            end else begin
                p = m_chk[0] ^ m_chk[3];
                m_chk.push_back(p);
                void'(m_chk.pop_front());
                if (rx != p) begin
                    if (m_err < 255) m_err++;
                    m_miss++;
                    if (m_miss == LOSS_BITS) begin
                        m_mode = 1;
                        m_chk.delete();
                        m_run  = 0;
                        m_miss = 0;
                    end
                end else begin
                    m_miss = 0;
                end
            end
        end
    endfunction

    task automatic compareField(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic checkOutput(string name);
        compareField($sformatf("%s.tx_bit", name), 32'(tx_bit), 32'(m_tx));
        compareField($sformatf("%s.busy", name), 32'(busy), 32'(m_mode != 0));
        compareField($sformatf("%s.locked", name), 32'(locked), 32'(m_mode == 2));
        compareField($sformatf("%s.err_count", name), 32'(err_count), 32'(m_err));
    endtask

    // Called at a falling edge; drives inputs, lets one rising edge pass, returns at the next falling edge
    task automatic applyStimulus(bit cv, bit [1:0] c, bit [7:0] b, bit rx);
        cmd_valid = cv;
        cmd       = c;
        seed_byte = b;
        rx_bit    = rx;
        @(posedge clk);
        if (ena) modelStep(cv, c, b, rx);
        @(negedge clk);
    endtask

    task automatic runAligned(int n, bit inv, string name);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, C_NOP, 8'h00, modelNextGen() ^ inv);
            checkOutput(name);
        end
    endtask

    typedef struct {
        bit       cv;
        bit [1:0] c;
        bit [7:0] b;
        bit       rx;
        bit       exp_busy;
        bit       exp_locked;
        bit       exp_tx;
    } vec_t;

    function automatic vec_t mkVec(bit cv, bit [1:0] c, bit [7:0] b, bit rx,
                                   bit eb, bit el, bit et);
        vec_t v;
        v.cv = cv; v.c = c; v.b = b; v.rx = rx;
        v.exp_busy = eb; v.exp_locked = el; v.exp_tx = et;
        return v;
    endfunction

    initial begin : watchdog
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        vec_t vecs[$];
        int   dut_at;
        int   mdl_at;
        int   r;
        bit   cv;
        bit [1:0] c;
        bit   rxv;

        rst_n = 1'b0; ena = 1'b1; cmd_valid = 1'b0; cmd = C_NOP; seed_byte = 8'h00; rx_bit = 1'b0;
        modelReset();
        repeat (2) @(negedge clk);
        compareField("reset.tx_bit", 32'(tx_bit), 32'd0);
        compareField("reset.busy", 32'(busy), 32'd0);
        compareField("reset.locked", 32'(locked), 32'd0);
        compareField("reset.err_count", 32'(err_count), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Short control sequences from reset with the seed still zero (fallback seed)
        vecs.push_back(mkVec(1'b0, C_NOP,   8'h00, 1'b0, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mkVec(1'b1, C_STOP,  8'h00, 1'b0, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mkVec(1'b1, C_LOAD,  8'h00, 1'b0, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mkVec(1'b1, C_START, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mkVec(1'b0, C_NOP,   8'h00, 1'b0, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mkVec(1'b1, C_LOAD,  8'h00, 1'b1, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mkVec(1'b1, C_STOP,  8'h00, 1'b0, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mkVec(1'b1, C_NOP,   8'h00, 1'b1, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mkVec(1'b1, C_START, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mkVec(1'b0, C_NOP,   8'h00, 1'b1, 1'b1, 1'b0, 1'b0));
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].cv, vecs[i].c, vecs[i].b, vecs[i].rx);
            compareField($sformatf("vec%0d.busy", i), 32'(busy), 32'(vecs[i].exp_busy));
            compareField($sformatf("vec%0d.locked", i), 32'(locked), 32'(vecs[i].exp_locked));
            compareField($sformatf("vec%0d.tx_bit", i), 32'(tx_bit), 32'(vecs[i].exp_tx));
            compareField($sformatf("vec%0d.err_count", i), 32'(err_count), 32'd0);
            checkOutput($sformatf("vec%0d", i));
        end

        // Fallback seed: counting the first generated bit as bit 0, bits 0..27 are 0 and bit 28 is 1
        applyStimulus(1'b1, C_START, 8'h00, 1'b0);
        for (int k = 0; k <= 28; k++) begin
            applyStimulus(1'b0, C_NOP, 8'h00, 1'b0);
            compareField($sformatf("fallback.bit%0d", k), 32'(tx_bit), 32'(k == 28));
            checkOutput("fallback");
        end
        compareField("fallback.busy", 32'(busy), 32'd1);
        compareField("fallback.locked", 32'(locked), 32'd0);

        // Loopback of the registered tx_bit; lock time comes from the model
        applyStimulus(1'b1, C_START, 8'h00, 1'b0);
        checkOutput("loopback_start");
        dut_at = 0;
        mdl_at = 0;
        for (int s = 1; s <= 200; s++) begin
            applyStimulus(1'b0, C_NOP, 8'h00, tx_bit);
            checkOutput("loopback");
            if (locked === 1'b1 && dut_at == 0) dut_at = s;
            if (m_mode == 2 && mdl_at == 0) mdl_at = s;
        end
        compareField("loopback.lock_sample", 32'(dut_at), 32'(mdl_at));
        for (int s = 0; s < 1000; s++) begin
            applyStimulus(1'b0, C_NOP, 8'h00, tx_bit);
            checkOutput("loopback_run");
        end
        compareField("loopback.err_count", 32'(err_count), 32'd0);
        compareField("loopback.locked", 32'(locked), 32'd1);

        // Error-free aligned stream: locked rises on exactly the 63rd sampled bit
        applyStimulus(1'b1, C_START, 8'h00, 1'b0);
        runAligned(62, 1'b0, "aligned_sync");
        compareField("aligned.locked_at_62", 32'(locked), 32'd0);
        runAligned(1, 1'b0, "aligned_lock");
        compareField("aligned.locked_at_63", 32'(locked), 32'd1);

        // Isolated single-bit errors are counted but keep lock
        for (int n = 0; n < 3; n++) begin
            runAligned(1, 1'b1, "single_err");
            runAligned(9, 1'b0, "single_gap");
        end
        compareField("single.err_count", 32'(err_count), 32'd3);
        compareField("single.locked", 32'(locked), 32'd1);

        // LOSS_BITS consecutive errors drop lock, then relock 63 samples later
        runAligned(4, 1'b1, "burst_err");
        compareField("burst.err_count", 32'(err_count), 32'd7);
        compareField("burst.locked", 32'(locked), 32'd0);
        compareField("burst.busy", 32'(busy), 32'd1);
        runAligned(62, 1'b0, "relock");
        compareField("relock.locked_at_62", 32'(locked), 32'd0);
        runAligned(1, 1'b0, "relock");
        compareField("relock.locked_at_63", 32'(locked), 32'd1);
        compareField("relock.err_count", 32'(err_count), 32'd7);

        // 300 spaced errors saturate the counter
        for (int n = 0; n < 300; n++) begin
            runAligned(1, 1'b1, "sat_err");
            runAligned(1, 1'b0, "sat_gap");
        end
        compareField("saturate.err_count", 32'(err_count), 32'd255);
        compareField("saturate.locked", 32'(locked), 32'd1);

        // ena low: commands and rx ignored, outputs hold
        ena = 1'b0;
        for (int n = 0; n < 5; n++) begin
            applyStimulus(1'b1, 2'($urandom_range(1, 3)), 8'($urandom), 1'($urandom));
            checkOutput("ena_low");
            compareField("ena_low.busy", 32'(busy), 32'd1);
            compareField("ena_low.locked", 32'(locked), 32'd1);
            compareField("ena_low.err_count", 32'(err_count), 32'd255);
        end
        ena = 1'b1;
        runAligned(5, 1'b0, "ena_resume");
        compareField("ena_resume.locked", 32'(locked), 32'd1);

        // Asynchronous reset between clock edges
        #2 rst_n = 1'b0;
        #1;
        compareField("async_reset.tx_bit", 32'(tx_bit), 32'd0);
        compareField("async_reset.busy", 32'(busy), 32'd0);
        compareField("async_reset.locked", 32'(locked), 32'd0);
        compareField("async_reset.err_count", 32'(err_count), 32'd0);
        modelReset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("post_reset");

        // Seed bytes shift in MSB-first
        applyStimulus(1'b1, C_LOAD, 8'h12, 1'b0);
        applyStimulus(1'b1, C_LOAD, 8'h34, 1'b0);
        applyStimulus(1'b1, C_LOAD, 8'h56, 1'b0);
        applyStimulus(1'b1, C_LOAD, 8'h78, 1'b0);
        checkOutput("seed_load");
        applyStimulus(1'b1, C_START, 8'h00, 1'b0);
        compareField("seed.gen_state", 32'(dut.u_gen.state), 32'h1234_5678);
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1'b0, C_NOP, 8'h00, 1'($urandom));
            checkOutput($sformatf("seed_bit%0d", k));
        end

        // STOP while still synchronising
        runAligned(10, 1'b0, "pre_stop");
        applyStimulus(1'b1, C_STOP, 8'h00, 1'b0);
        compareField("stop.busy", 32'(busy), 32'd0);
        compareField("stop.tx_bit", 32'(tx_bit), 32'd0);
        compareField("stop.locked", 32'(locked), 32'd0);
        checkOutput("stop");

        // Randomized traffic: alternating aligned-with-errors and random rx phases
        for (int i = 0; i < 4000; i++) begin
            ena = (i == 0) ? 1'b1 : ($urandom_range(0, 9) != 0);
            r   = $urandom_range(0, 999);
            cv  = 1'b0;
            c   = C_NOP;
            if (i == 0 || r < 4) begin
                cv = 1'b1; c = C_START;
            end else if (r < 7) begin
                cv = 1'b1; c = C_STOP;
            end else if (r < 40) begin
                cv = 1'b1; c = C_LOAD;
            end else if (r < 60) begin
                cv = 1'b1; c = C_NOP;
            end
            if ((i / 500) % 2 == 0) begin
                rxv = modelNextGen() ^ ($urandom_range(0, 29) == 0);
            end else begin
                rxv = 1'($urandom);
            end
            applyStimulus(cv, c, 8'($urandom), rxv);
            checkOutput("random");
        end
        ena = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
